// File: rtl/fpga_transmitter_if.sv
// -----------------------------------------------------------------------------
// fpga_transmitter_if
//
// Purpose : bundles the local byte handshake, the remote acknowledge and the
//           serial line outputs of the FPGA-to-FPGA transmitter.
//
// Signals :
//   data_in     [7:0] byte to transmit, sampled on an accepted load
//   load              local request to transmit data_in
//   acknowledge       remote receiver acknowledge (asynchronous to the clock)
//   data              serial data line, MSB first
//   send              high while data bits are on the line
//   finish            high for one bit period after the last bit
//   ready             transmitter idle and able to accept load
//   done              one-cycle pulse when the acknowledge is received
//   error             one-cycle pulse on acknowledge timeout
//
// Modports:
//   master : local producer / remote-side environment driving the transmitter
//   slave  : the transmitter itself
// -----------------------------------------------------------------------------
interface fpga_transmitter_if;
   logic [7:0] data_in;
   logic       load;
   logic       acknowledge;
   logic       data;
   logic       send;
   logic       finish;
   logic       ready;
   logic       done;
   logic       error;

   modport master (
      output data_in,
      output load,
      output acknowledge,
      input  data,
      input  send,
      input  finish,
      input  ready,
      input  done,
      input  error
   );

   modport slave (
      input  data_in,
      input  load,
      input  acknowledge,
      output data,
      output send,
      output finish,
      output ready,
      output done,
      output error
   );
endinterface

// File: rtl/fpga_transmitter.sv
// -----------------------------------------------------------------------------
// fpga_transmitter
//
// Purpose : sending end of the send/finish/acknowledge inter-board protocol.
//           A byte accepted from the local side is shifted out MSB first, each
//           bit held for BIT_CYCLES clocks while send is high, followed by one
//           bit period of finish. The transmitter then waits up to ACK_TIMEOUT
//           cycles for the remote acknowledge and reports done or error.
//
// Parameters:
//   BIT_CYCLES  : clocks per bit and per finish period (>= 1)
//   ACK_TIMEOUT : WAIT_ACK cycles allowed before aborting (>= 1)
//
// Ports:
//   clock : system clock, all state changes on the rising edge
//   reset : asynchronous, active-high reset
//   link  : fpga_transmitter_if slave modport (handshake, ack, line outputs)
// -----------------------------------------------------------------------------
module fpga_transmitter #(
   parameter int BIT_CYCLES  = 4,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic               clock,
   input  logic               reset,
   fpga_transmitter_if.slave  link
);

   // Counter widths. A single-cycle bit period still needs a 1-bit counter.
   localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT    = 3'd1,
      FINISH   = 3'd2,
      WAIT_ACK = 3'd3,
      RELEASE  = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [7:0]        shreg_r;
   logic [7:0]        shreg_s;
   logic [2:0]        bit_cnt_r;
   logic [2:0]        bit_cnt_s;
   logic [CYC_W-1:0]  cyc_cnt_r;
   logic [CYC_W-1:0]  cyc_cnt_s;
   logic [TO_W-1:0]   to_cnt_r;
   logic [TO_W-1:0]   to_cnt_s;

   logic              ack_meta_r;
   logic              ack_sync_r;
   logic              ack_s;

   logic              data_r;
   logic              data_s;
   logic              send_r;
   logic              send_s;
   logic              finish_r;
   logic              finish_s;
   logic              ready_r;
   logic              ready_s;
   logic              done_s;
   logic              error_s;

   // Two-flop synchronizer bringing the remote acknowledge into the clock domain.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ack_meta_r <= 1'b0;
         ack_sync_r <= 1'b0;
      end else begin
         ack_meta_r <= link.acknowledge;
         ack_sync_r <= ack_meta_r;
      end
   end

   assign ack_s = ack_sync_r;

   // State, datapath and line-output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         shreg_r   <= 8'h00;
         bit_cnt_r <= 3'd0;
         cyc_cnt_r <= '0;
         to_cnt_r  <= '0;
         data_r    <= 1'b0;
         send_r    <= 1'b0;
         finish_r  <= 1'b0;
         ready_r   <= 1'b1;
      end else begin
         state_r   <= state_s;
         shreg_r   <= shreg_s;
         bit_cnt_r <= bit_cnt_s;
         cyc_cnt_r <= cyc_cnt_s;
         to_cnt_r  <= to_cnt_s;
         data_r    <= data_s;
         send_r    <= send_s;
         finish_r  <= finish_s;
         ready_r   <= ready_s;
      end
   end

   // Next-state, datapath update and output decode.
   always_comb begin
      state_s   = state_r;
      shreg_s   = shreg_r;
      bit_cnt_s = bit_cnt_r;
      cyc_cnt_s = cyc_cnt_r;
      to_cnt_s  = to_cnt_r;
      done_s    = 1'b0;
      error_s   = 1'b0;

      case (state_r)
         IDLE: begin
            // The synchronized acknowledge is deliberately not looked at here.
            if (link.load) begin
               state_s   = SHIFT;
               shreg_s   = link.data_in;
               bit_cnt_s = 3'd0;
               cyc_cnt_s = '0;
            end else begin
               state_s   = IDLE;
            end
         end

         SHIFT: begin
            if (cyc_cnt_r == CYC_LAST) begin
               cyc_cnt_s = '0;
               shreg_s   = {shreg_r[6:0], 1'b0};
               if (bit_cnt_r == 3'd7) begin
                  state_s   = FINISH;
                  bit_cnt_s = 3'd0;
               end else begin
                  bit_cnt_s = bit_cnt_r + 3'd1;
               end
            end else begin
               cyc_cnt_s = cyc_cnt_r + CYC_W'(1);
            end
         end

         FINISH: begin
            if (cyc_cnt_r == CYC_LAST) begin
               state_s   = WAIT_ACK;
               cyc_cnt_s = '0;
               to_cnt_s  = '0;
            end else begin
               cyc_cnt_s = cyc_cnt_r + CYC_W'(1);
            end
         end

         WAIT_ACK: begin
            // Acknowledge is checked first so it wins over a coincident timeout.
            if (ack_s) begin
               done_s  = 1'b1;
               state_s = RELEASE;
            end else if (to_cnt_r == TO_LAST) begin
               error_s = 1'b1;
               state_s = IDLE;
            end else begin
               to_cnt_s = to_cnt_r + TO_W'(1);
            end
         end

         RELEASE: begin
            // A held acknowledge must drop before another frame can complete.
            if (!ack_s) begin
               state_s = IDLE;
            end else begin
               state_s = RELEASE;
            end
         end

         default: begin
            state_s = IDLE;
         end
      endcase

      // Line outputs are decoded from the next state so the registered copies
      // line up with the state register.
      ready_s  = (state_s == IDLE);
      send_s   = (state_s == SHIFT);
      finish_s = (state_s == FINISH);
      data_s   = (state_s == SHIFT) & shreg_s[7];
   end

   assign link.data   = data_r;
   assign link.send   = send_r;
   assign link.finish = finish_r;
   assign link.ready  = ready_r;
   // done/error come straight from registered state, ack_s and the timeout
   // count so they appear in the same cycle the condition is recognised.
   assign link.done   = done_s;
   assign link.error  = error_s;

endmodule

// File: tb/tb_fpga_transmitter.sv
// -----------------------------------------------------------------------------
// tb_fpga_transmitter
//
// Two transmitters: dut_a (BIT_CYCLES=4, ACK_TIMEOUT=16) and dut_b
// (BIT_CYCLES=1, ACK_TIMEOUT=16). 'sel' routes the stimulus to one of them and
// picks which one is observed. Expected waveforms come from a timeline model:
// for a load accepted at edge 0, sample t (taken 1ns after edge t) is predicted
// from frame arithmetic and from the window in which the synchronized
// acknowledge is high.
// Observed vector layout: {ready, data, send, finish, done, error}.
// -----------------------------------------------------------------------------
module tb_fpga_transmitter;

   localparam int BA    = 4;
   localparam int TA    = 16;
   localparam int BB    = 1;
   localparam int TBB   = 16;
   localparam int NEVER = 100000;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       sel = 1'b0;
   logic       drv_load = 1'b0;
   logic       drv_ack = 1'b0;
   logic [7:0] drv_data = 8'h00;
   logic [5:0] obs;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   fpga_transmitter_if bus_a ();
   fpga_transmitter_if bus_b ();

   assign bus_a.data_in     = drv_data;
   assign bus_a.load        = !sel && drv_load;
   assign bus_a.acknowledge = !sel && drv_ack;
   assign bus_b.data_in     = drv_data;
   assign bus_b.load        = sel && drv_load;
   assign bus_b.acknowledge = sel && drv_ack;

   assign obs = sel ? {bus_b.ready, bus_b.data, bus_b.send, bus_b.finish, bus_b.done, bus_b.error}
                    : {bus_a.ready, bus_a.data, bus_a.send, bus_a.finish, bus_a.done, bus_a.error};

   fpga_transmitter #(.BIT_CYCLES(BA), .ACK_TIMEOUT(TA)) dut_a (
      .clock (clock),
      .reset (reset),
      .link  (bus_a)
   );

   fpga_transmitter #(.BIT_CYCLES(BB), .ACK_TIMEOUT(TBB)) dut_b (
      .clock (clock),
      .reset (reset),
      .link  (bus_b)
   );

   // Synchronized acknowledge at sample s: high from the sample after the edge
   // that first sees acknowledge high, through the sample of the edge before
   // the one that first sees it low.
   function automatic bit acks(input int s, input int a_rise, input int a_fall);
      return (s >= a_rise + 1) && (s <= a_fall);
   endfunction

   // Expected {ready,data,send,finish,done,error} at sample t of a frame.
   function automatic logic [5:0] model(input int t, input logic [7:0] b, input int bc,
                                        input int to, input int a_rise, input int a_fall);
      logic [5:0] r;
      int w;
      int td;
      int s;
      r  = 6'b000000;
      w  = 9 * bc;
      td = -1;
      if (t < 8 * bc) begin
         r[3] = 1'b1;
         r[4] = b[3'(7 - t / bc)];
      end else if (t < w) begin
         r[2] = 1'b1;
      end else begin
         for (int k = w; k <= w + to; k++)
            if (td < 0 && acks(k, a_rise, a_fall)) td = k;
         if (td < 0) begin
            if (t == w + to) r[0] = 1'b1;
            else if (t > w + to) r[5] = 1'b1;
         end else if (t == td) begin
            r[1] = 1'b1;
         end else if (t > td) begin
            s = td + 1;
            while (s < NEVER && acks(s, a_rise, a_fall)) s++;
            if (t > s) r[5] = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic int first_ready(input int bc, input int to, input int a_rise, input int a_fall);
      logic [5:0] v;
      for (int t = 0; t < 4000; t++) begin
         v = model(t, 8'h00, bc, to, a_rise, a_fall);
         if (v[5]) return t;
      end
      return 4000;
   endfunction

   // Present a byte with load for one edge; returns at sample 0 of the frame.
   task automatic load_byte(input logic [7:0] b);
      drv_data = b;
      drv_load = 1'b1;
      @(posedge clock); #1;
      drv_load = 1'b0;
      drv_data = 8'($urandom);
   endtask

   task automatic idle_cycles(input int n);
      drv_load = 1'b0;
      drv_ack  = 1'b0;
      repeat (n) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      sel = 1'b0; #1;
      checks++;
      if (obs !== 6'b100000) begin
         errors++;
         $display("FAIL reset_a got %b want %b", obs, 6'b100000);
      end
      sel = 1'b1; #1;
      checks++;
      if (obs !== 6'b100000) begin
         errors++;
         $display("FAIL reset_b got %b want %b", obs, 6'b100000);
      end
      sel = 1'b0;
      reset = 1'b0;
      idle_cycles(2);
   endtask

   task automatic test_frame_a5();
      int ar, af, n;
      logic [5:0] exp;
      ar = 9 * BA + 5;
      af = ar + 4;
      n  = first_ready(BA, TA, ar + 1, af + 1) + 3;
      load_byte(8'hA5);
      for (int t = 0; t < n; t++) begin
         exp = model(t, 8'hA5, BA, TA, ar + 1, af + 1);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL frame_a5 t=%0d got %b want %b", t, obs, exp);
         end
         if (t == ar) drv_ack = 1'b1;
         if (t == af) drv_ack = 1'b0;
         @(posedge clock); #1;
      end
      idle_cycles(3);
   endtask

   // ack_at < 0 keeps acknowledge low for the whole frame.
   task automatic test_timeout(input int ack_at);
      int ar, n;
      logic [7:0] b;
      logic [5:0] exp;
      b  = 8'($urandom);
      ar = (ack_at < 0) ? NEVER : ack_at;
      n  = first_ready(BA, TA, ar + 1, ar + 4) + 3;
      load_byte(b);
      for (int t = 0; t < n; t++) begin
         exp = model(t, b, BA, TA, ar + 1, ar + 4);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL timeout t=%0d ack_at=%0d got %b want %b", t, ack_at, obs, exp);
         end
         if (t == ar) drv_ack = 1'b1;
         if (t == ar + 3) drv_ack = 1'b0;
         @(posedge clock); #1;
      end
      idle_cycles(4);
   endtask

   task automatic test_random_frames();
      int ar, af, n;
      logic [7:0] b;
      logic [5:0] exp;
      for (int f = 0; f < 5; f++) begin
         b  = 8'($urandom);
         ar = $urandom_range(0, 9 * BA + TA + 2);
         af = ar + $urandom_range(1, 6);
         n  = first_ready(BA, TA, ar + 1, af + 1) + 2;
         load_byte(b);
         for (int t = 0; t < n; t++) begin
            exp = model(t, b, BA, TA, ar + 1, af + 1);
            checks++;
            if (obs !== exp) begin
               errors++;
               $display("FAIL random f=%0d b=%h t=%0d got %b want %b", f, b, t, obs, exp);
            end
            if (t == ar) drv_ack = 1'b1;
            if (t == af) drv_ack = 1'b0;
            @(posedge clock); #1;
         end
         idle_cycles(4);
      end
   endtask

   task automatic test_held_ack();
      int fd, r1, org2, n;
      logic [5:0] exp;
      drv_ack = 1'b1;
      repeat (4) begin
         @(posedge clock); #1;
      end
      checks++;
      if (obs !== 6'b100000) begin
         errors++;
         $display("FAIL held_ack_idle got %b want %b", obs, 6'b100000);
      end
      fd   = 50;
      r1   = first_ready(BA, TA, -10, fd + 1);
      org2 = r1 + 1;
      n    = org2 + 9 * BA + TA + 3;
      drv_data = 8'h01;
      drv_load = 1'b1;
      @(posedge clock); #1;
      // load stays high with a different byte for the rest of the first frame
      drv_data = 8'h80;
      for (int t = 0; t < n; t++) begin
         if (t < org2) exp = model(t, 8'h01, BA, TA, -10, fd + 1);
         else          exp = model(t - org2, 8'h80, BA, TA, NEVER, NEVER);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL held_ack t=%0d got %b want %b", t, obs, exp);
         end
         if (t == fd)   drv_ack = 1'b0;
         if (t == org2) drv_load = 1'b0;
         @(posedge clock); #1;
      end
      idle_cycles(3);
   endtask

   task automatic test_reset_mid_shift();
      int rs, ar, n;
      logic [7:0] b;
      logic [5:0] exp;
      b  = 8'($urandom);
      rs = 4 * BA + 1;
      load_byte(b);
      for (int t = 0; t <= rs; t++) begin
         exp = model(t, b, BA, TA, NEVER, NEVER);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL pre_reset t=%0d got %b want %b", t, obs, exp);
         end
         if (t < rs) begin
            @(posedge clock); #1;
         end
      end
      // Mid-cycle, away from any clock edge.
      #2 reset = 1'b1;
      #1;
      checks++;
      if (obs !== 6'b100000) begin
         errors++;
         $display("FAIL async_reset got %b want %b", obs, 6'b100000);
      end
      reset = 1'b0;
      idle_cycles(2);
      checks++;
      if (obs !== 6'b100000) begin
         errors++;
         $display("FAIL after_reset got %b want %b", obs, 6'b100000);
      end
      ar = 9 * BA + $urandom_range(0, 6);
      n  = first_ready(BA, TA, ar + 1, ar + 3) + 2;
      load_byte(8'hFF);
      for (int t = 0; t < n; t++) begin
         exp = model(t, 8'hFF, BA, TA, ar + 1, ar + 3);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL ff_frame t=%0d got %b want %b", t, obs, exp);
         end
         if (t == ar) drv_ack = 1'b1;
         if (t == ar + 2) drv_ack = 1'b0;
         @(posedge clock); #1;
      end
      idle_cycles(3);
   endtask

   task automatic test_load_ignored();
      int ar, n;
      logic [5:0] exp;
      ar = 9 * BA + $urandom_range(1, 8);
      n  = first_ready(BA, TA, ar + 1, ar + 3) + 2;
      load_byte(8'hC3);
      for (int t = 0; t < n; t++) begin
         exp = model(t, 8'hC3, BA, TA, ar + 1, ar + 3);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL load_ignored t=%0d got %b want %b", t, obs, exp);
         end
         if (t == 10) begin
            drv_load = 1'b1;
            drv_data = 8'h3C;
         end
         if (t == 11) drv_load = 1'b0;
         if (t == ar) drv_ack = 1'b1;
         if (t == ar + 2) drv_ack = 1'b0;
         @(posedge clock); #1;
      end
      idle_cycles(3);
   endtask

   task automatic test_b1();
      int ar, af, n;
      logic [5:0] exp;
      sel = 1'b1;
      idle_cycles(2);
      ar = 10;
      af = 14;
      n  = first_ready(BB, TBB, ar + 1, af + 1) + 3;
      load_byte(8'h80);
      for (int t = 0; t < n; t++) begin
         exp = model(t, 8'h80, BB, TBB, ar + 1, af + 1);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL b1_frame t=%0d got %b want %b", t, obs, exp);
         end
         if (t == ar) drv_ack = 1'b1;
         if (t == af) drv_ack = 1'b0;
         @(posedge clock); #1;
      end
      idle_cycles(3);
      sel = 1'b0;
      idle_cycles(2);
   endtask

   initial begin
      test_reset();
      test_frame_a5();
      test_timeout(-1);
      // acknowledge first visible exactly on the expiry cycle: done must win
      test_timeout(9 * BA + TA - 2);
      test_timeout(9 * BA + TA - 1);
      test_held_ack();
      test_reset_mid_shift();
      test_load_ignored();
      test_random_frames();
      test_b1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
